restador_serial: RTL and testbench

Bit-serial N-bit subtractor computing Dif = A − B, LSB first, one bit per clock through a single 1-bit full-subtractor cell and a registered borrow. It is the subtracting counterpart of the combinational 1-bit full adder (Sumador) used in the arithmetic lab blocks. It trades latency for area and adds a start/busy/done handshake so a controller or testbench can sequence operations.

---
 rtl/restador_serial_pkg.sv | 12 +
 rtl/restador_completo.sv | 13 +
 rtl/restador_serial.sv | 112 +++++++++++
 tb/tb_restador_serial.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/restador_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package restador_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DEF_N = 4;

endpackage

// File: rtl/restador_completo.sv
// Combinational 1-bit full subtractor: Dif = A - B - BIn, BOut is the borrow out.
module restador_completo (
   input  logic A,
   input  logic B,
   input  logic BIn,
   output logic Dif,
   output logic BOut
);

   assign Dif  = A ^ B ^ BIn;
   assign BOut = (~A & B) | (~(A ^ B) & BIn);

endmodule

// File: rtl/restador_serial.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow and a start/busy/done handshake.
module restador_serial
   import restador_serial_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Dif,
   output logic         BOut,
   output logic         busy,
   output logic         done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_e        state_q, state_d;
   logic [N-1:0]  sa_q, sa_d;
   logic [N-1:0]  sb_q, sb_d;
   logic [N-1:0]  res_q, res_d;
   logic          bor_q, bor_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  dif_q, dif_d;
   logic          bout_q, bout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          cell_d, cell_bo;

   restador_completo u_cell (
      .A    (sa_q[0]),
      .B    (sb_q[0]),
      .BIn  (bor_q),
      .Dif  (cell_d),
      .BOut (cell_bo)
   );

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      bor_d   = bor_q;
      cnt_d   = cnt_q;
      dif_d   = dif_q;
      bout_d  = bout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               sa_d    = A;
               sb_d    = B;
               bor_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            res_d = {cell_d, res_q[N-1:1]};
            bor_d = cell_bo;
            cnt_d = cnt_q + CW'(1);
            // Last bit: publish the finished word and borrow together.
            if (cnt_q == CW'(N-1)) begin
               state_d = ST_DONE;
               dif_d   = {cell_d, res_q[N-1:1]};
               bout_d  = cell_bo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         bor_q   <= 1'b0;
         cnt_q   <= '0;
         dif_q   <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         bor_q   <= bor_d;
         cnt_q   <= cnt_d;
         dif_q   <= dif_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Dif  = dif_q;
   assign BOut = bout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_restador_serial.sv
// Scoreboard bench for restador_serial (N=4) plus a truth-table check of the cell.
module tb_restador_serial;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] A, B;
   logic [N-1:0] Dif;
   logic         BOut, busy, done;

   logic         ca, cb, cbi, cd, cbo;

   int n_chk = 0;
   int n_err = 0;
   int n_done = 0;
   int cyc = 0;

   logic [N:0] sb_q[$];

   restador_serial #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Dif   (Dif),
      .BOut  (BOut),
      .busy  (busy),
      .done  (done)
   );

   restador_completo u_cell (
      .A    (ca),
      .B    (cb),
      .BIn  (cbi),
      .Dif  (cd),
      .BOut (cbo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (done) n_done++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one start at a negedge, log the expected result, drop start a cycle later.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] d;
      d = a - b;
      A = a;
      B = b;
      start = 1'b1;
      sb_q.push_back({(a < b), d});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      logic [N:0] e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_dif"}, 32'(Dif), 32'(e[N-1:0]));
         chk({tag, "_bout"}, 32'(BOut), 32'(e[N]));
      end
   endtask

   task automatic wait_done(input string tag);
      int i;
      i = 0;
      while (!done && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
      else pop_check(tag);
   endtask

   // Full op with exact handshake timing: busy for N cycles, done in cycle k+N+1.
   task automatic op_timed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
      start_op(a, b);
      for (int j = 0; j < N; j++) begin
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      pop_check(tag);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int d0, last;
      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      ca = 0; cb = 0; cbi = 0;

      // Cell truth table against arithmetic a - b - bi.
      for (int k = 0; k < 8; k++) begin
         int diff;
         {ca, cb, cbi} = 3'(k);
         #1;
         diff = int'(ca) - int'(cb) - int'(cbi);
         chk("cell_d", 32'(cd), 32'(diff & 1));
         chk("cell_bo", 32'(cbo), (diff < 0) ? 32'd1 : 32'd0);
      end

      @(negedge clk);
      @(negedge clk);
      chk("rst_dif", 32'(Dif), 32'd0);
      chk("rst_bout", 32'(BOut), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      op_timed("a9b3", 4'd9, 4'd3);
      op_timed("a3b9", 4'd3, 4'd9);
      op_timed("a0b1", 4'd0, 4'd1);
      op_timed("a0b0", 4'd0, 4'd0);

      // start during SHIFT is ignored; exactly one done pulse follows.
      d0 = n_done;
      start_op(4'd9, 4'd3);
      A = 4'd15;
      B = 4'd15;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign");
      repeat (10) @(negedge clk);
      chk("ign_one_done", 32'(n_done - d0), 32'd1);

      // Reset two cycles into SHIFT wipes outputs; previous Dif must go to 0.
      start_op(4'd5, 4'd2);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_dif", 32'(Dif), 32'd0);
      chk("mid_rst_bout", 32'(BOut), 32'd0);
      sb_q.delete();
      @(negedge clk);
      op_timed("post_rst", 4'd12, 4'd5);

      // Start held high: results every N+1 cycles, each from its own accepting edge.
      A = 4'($urandom_range(0, 15));
      B = 4'($urandom_range(0, 15));
      start = 1'b1;
      sb_q.push_back({(A < B), 4'(A - B)});
      last = -1;
      for (int r = 0; r < 6; r++) begin
         @(negedge clk);
         wait_done("b2b");
         if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'd5);
         last = cyc;
         if (r < 5) begin
            A = 4'($urandom_range(0, 15));
            B = 4'($urandom_range(0, 15));
            sb_q.push_back({(A < B), 4'(A - B)});
         end else begin
            start = 1'b0;
         end
      end
      repeat (3) @(negedge clk);

      // Exhaustive sweep of all operand pairs.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            start_op(4'(a), 4'(b));
            wait_done("exh");
            @(negedge clk);
         end
      end

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
